// File: rtl/decode_5to32_pkg.sv
// Shared types and constants for the 5-to-32 one-hot decoder.
// Group geometry (4 groups of 8) ties the predecode to the 3-to-8 blocks.
package decode_pkg;

  localparam int SEL_W   = 5;
  localparam int OUT_W   = 32;
  localparam int GRP_W   = 8;
  localparam int NUM_GRP = 4;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [OUT_W-1:0] onehot_t;

  function automatic onehot_t inactive_val(input bit active_low);
    return active_low ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
  endfunction

endpackage

// File: rtl/decode_5to32_decode_3to8.sv
// Combinational 3-to-8 one-hot decoder; all outputs low when disabled.
module decode_3to8 (
  input  logic       en,
  input  logic [2:0] sel,
  output logic [7:0] y
);

  always_comb begin
    y = 8'h00;
    if (en) y[sel] = 1'b1;
  end

endmodule

// File: rtl/decode_5to32.sv
// Registered 5-to-32 one-hot decoder with enable and selectable output polarity.
// Build option: DECODE_5TO32_HOLD_EN keeps the last decode while en is low.
module decode_5to32
  import decode_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0,
  parameter int SEL_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] A,
  input  logic             en,
  output logic [31:0]      out,
  output logic             out_valid
);

  if (SEL_W != 5) begin : g_bad_sel_w
    $error("decode_5to32: SEL_W must be 5");
  end

  logic [NUM_GRP-1:0] grp_en;
  onehot_t            dec;
  onehot_t            out_d;

  always_comb begin
    grp_en         = '0;
    grp_en[A[4:3]] = en;
  end

  for (genvar k = 0; k < NUM_GRP; k++) begin : g_grp
    decode_3to8 u_dec (
      .en  (grp_en[k]),
      .sel (A[2:0]),
      .y   (dec[GRP_W*k +: GRP_W])
    );
  end

  // Invert before the flop so the registered output is glitch-free in either polarity.
  assign out_d = ACTIVE_LOW ? ~dec : dec;

  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= inactive_val(ACTIVE_LOW);
      out_valid <= 1'b0;
    end else begin
`ifdef DECODE_5TO32_HOLD_EN
      if (en) begin
        out       <= out_d;
        out_valid <= 1'b1;
      end
`else
      out       <= out_d;
      out_valid <= en;
`endif
    end
  end

endmodule

// File: tb/tb_decode_5to32.sv
// Directed self-checking bench for decode_5to32, covering both output polarities.
module tb_decode_5to32;

  logic        clk;
  logic        rst;
  logic [4:0]  A;
  logic        en;
  logic [31:0] out_hi, out_lo;
  logic        vld_hi, vld_lo;

  int n_cmp = 0;
  int n_err = 0;

  decode_5to32 #(.ACTIVE_LOW(1'b0), .SEL_W(5)) dut (
    .clk(clk), .rst(rst), .A(A), .en(en), .out(out_hi), .out_valid(vld_hi)
  );

  decode_5to32 #(.ACTIVE_LOW(1'b1), .SEL_W(5)) dut_al (
    .clk(clk), .rst(rst), .A(A), .en(en), .out(out_lo), .out_valid(vld_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive at negedge, let one rising edge pass, sample at the following negedge.
  task automatic cycle(input logic r, input logic [4:0] a, input logic e);
    rst = r;
    A   = a;
    en  = e;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_hi(input string name, input logic [31:0] exp_out, input logic exp_vld);
    n_cmp++;
    if (out_hi !== exp_out) begin
      n_err++;
      $display("FAIL %s out: got %h expected %h", name, out_hi, exp_out);
    end
    n_cmp++;
    if (vld_hi !== exp_vld) begin
      n_err++;
      $display("FAIL %s out_valid: got %b expected %b", name, vld_hi, exp_vld);
    end
  endtask

  task automatic test_reset;
    cycle(1'b1, 5'd7, 1'b1);
    cycle(1'b1, 5'd7, 1'b1);
    chk_hi("reset", 32'h0000_0000, 1'b0);
    n_cmp++;
    if (out_lo !== 32'hFFFF_FFFF || vld_lo !== 1'b0) begin
      n_err++;
      $display("FAIL reset_al: got %h/%b expected ffffffff/0", out_lo, vld_lo);
    end
    cycle(1'b0, 5'd7, 1'b1);
    chk_hi("reset_release", 32'h0000_0080, 1'b1);
  endtask

  task automatic test_sweep;
    logic [31:0] exp_v;
    for (int i = 0; i < 32; i++) begin
      exp_v = 32'h1 << i;
      cycle(1'b0, 5'(i), 1'b1);
      chk_hi($sformatf("sweep_a%0d", i), exp_v, 1'b1);
      n_cmp++;
      if ($countones(out_hi) != 1) begin
        n_err++;
        $display("FAIL sweep_onehot_a%0d: got %h expected exactly one bit", i, out_hi);
      end
      n_cmp++;
      if (out_lo !== ~exp_v) begin
        n_err++;
        $display("FAIL sweep_al_a%0d: got %h expected %h", i, out_lo, ~exp_v);
      end
    end
  endtask

  task automatic test_enable_off;
    cycle(1'b0, 5'd5, 1'b1);
    chk_hi("en_on_a5", 32'h0000_0020, 1'b1);
    cycle(1'b0, 5'd5, 1'b0);
`ifdef DECODE_5TO32_HOLD_EN
    chk_hi("en_off_a5", 32'h0000_0020, 1'b1);
`else
    chk_hi("en_off_a5", 32'h0000_0000, 1'b0);
`endif
    cycle(1'b0, 5'd9, 1'b0);
`ifdef DECODE_5TO32_HOLD_EN
    chk_hi("en_off_a9", 32'h0000_0020, 1'b1);
`else
    chk_hi("en_off_a9", 32'h0000_0000, 1'b0);
`endif
    cycle(1'b0, 5'd9, 1'b1);
    chk_hi("en_back_on_a9", 32'h0000_0200, 1'b1);
  endtask

  task automatic test_reset_mid;
    cycle(1'b0, 5'd10, 1'b1);
    chk_hi("mid_a10", 32'h0000_0400, 1'b1);
    cycle(1'b0, 5'd11, 1'b1);
    chk_hi("mid_a11", 32'h0000_0800, 1'b1);
    cycle(1'b1, 5'd12, 1'b1);
    chk_hi("mid_rst_a12", 32'h0000_0000, 1'b0);
    cycle(1'b0, 5'd13, 1'b1);
    chk_hi("mid_a13", 32'h0000_2000, 1'b1);
  endtask

  task automatic test_active_low;
    cycle(1'b0, 5'd3, 1'b1);
    n_cmp++;
    if (out_lo !== 32'hFFFF_FFF7 || vld_lo !== 1'b1) begin
      n_err++;
      $display("FAIL al_a3: got %h/%b expected fffffff7/1", out_lo, vld_lo);
    end
    cycle(1'b0, 5'd3, 1'b0);
    n_cmp++;
`ifdef DECODE_5TO32_HOLD_EN
    if (out_lo !== 32'hFFFF_FFF7 || vld_lo !== 1'b1) begin
      n_err++;
      $display("FAIL al_en_off: got %h/%b expected fffffff7/1", out_lo, vld_lo);
    end
`else
    if (out_lo !== 32'hFFFF_FFFF || vld_lo !== 1'b0) begin
      n_err++;
      $display("FAIL al_en_off: got %h/%b expected ffffffff/0", out_lo, vld_lo);
    end
`endif
    cycle(1'b1, 5'd3, 1'b1);
    n_cmp++;
    if (out_lo !== 32'hFFFF_FFFF || vld_lo !== 1'b0) begin
      n_err++;
      $display("FAIL al_reset: got %h/%b expected ffffffff/0", out_lo, vld_lo);
    end
  endtask

  task automatic test_group_bounds;
    logic [4:0]  av [6];
    logic [31:0] ev [6];
    av = '{5'd7, 5'd8, 5'd15, 5'd16, 5'd23, 5'd24};
    ev = '{32'h0000_0080, 32'h0000_0100, 32'h0000_8000,
           32'h0001_0000, 32'h0080_0000, 32'h0100_0000};
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, av[i], 1'b1);
      chk_hi($sformatf("grp_a%0d", av[i]), ev[i], 1'b1);
    end
  endtask

  initial begin
    rst = 1'b1;
    A   = 5'd0;
    en  = 1'b0;
    @(negedge clk);
    test_reset();
    test_sweep();
    test_enable_off();
    test_reset_mid();
    test_active_low();
    test_group_bounds();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
